hex_display_sequencer: RTL
==========================

Name: hex_display_sequencer

Overview:
- Avalon-MM master that drives the memory-mapped hex-to-7-segment display slave.
- Accepts a packed NUM_SEGMENT-digit hex value over a valid/ready handshake.
- Issues one single-beat write per digit, to word address 0..NUM_SEGMENT-1, honouring waitrequest.
- Keeps a shadow copy of the digits last written and skips digits that have not changed, unless a forced refresh is requested.

Parameters:
- NUM_SEGMENT, 6, number of digits / slave word addresses.
- ADDR_W, 3, width of avm_address_o; must satisfy 2**ADDR_W >= NUM_SEGMENT.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- value_i  in  NUM_SEGMENT*4  packed digits; digit k = value_i[4k+3:4k], sent to address k
- force_i  in  1  sampled with value_i; 1 = write all digits regardless of shadow
- valid_i  in  1  request valid
- ready_o  out  1  sequencer can accept a request
- busy_o  out  1  request in progress (state != IDLE)
- done_o  out  1  one-cycle pulse when a request finishes
- avm_address_o  out  ADDR_W  slave word address
- avm_byteenable_o  out  4  byte enables
- avm_write_o  out  1  write strobe
- avm_writedata_o  out  32  write data
- avm_waitrequest_i  in  1  slave stall

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, idx=0, shadow digits=0, shadow_valid=0.
  - Outputs: ready_o=1, busy_o=0, done_o=0, avm_write_o=0, avm_address_o=0, avm_byteenable_o=0, avm_writedata_o=0.
- FSM states: IDLE, SCAN, WRITE, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o: capture value_i into req_value, capture force_i into req_force, set idx=0, go to SCAN.
- SCAN (one cycle per digit):
  - need_write = req_force | ~shadow_valid | (req_value digit[idx] != shadow[idx]).
  - need_write=1 → WRITE.
  - need_write=0 and idx==NUM_SEGMENT-1 → DONE.
  - need_write=0 otherwise → idx+1, stay in SCAN.
- WRITE:
  - avm_write_o=1, avm_address_o=idx, avm_byteenable_o=4'b0001, avm_writedata_o={28'b0, digit[idx]}.
  - Address, data and byteenable are registered outputs, stable while avm_waitrequest_i=1.
  - A beat is accepted on a cycle where avm_write_o=1 and avm_waitrequest_i=0. On acceptance: shadow[idx] <= digit.
  - After acceptance: if idx==NUM_SEGMENT-1 → DONE, else idx+1 → SCAN.
  - avm_write_o deasserts the cycle after acceptance.
- DONE (one cycle):
  - done_o=1, shadow_valid <= 1, then → IDLE.
- Outside WRITE: avm_write_o=0, avm_byteenable_o=0. Address and data hold their last values.
- ready_o=1 only in IDLE. valid_i asserted outside IDLE is ignored; no queueing. A requester must hold valid_i until ready_o is seen.
- Timing, with the request accepted at clock edge E0 and zero wait states:
  - Full write of 6 digits: SCAN/WRITE alternate over cycles 1..12, DONE in cycle 13, ready_o=1 in cycle 14.
  - No digits changed: SCAN over cycles 1..6, DONE in cycle 7.
  - Each waitrequest cycle adds one cycle.
- Digits are 4-bit hex values; no width conversion beyond zero-extension into writedata.
- Changes on value_i after capture have no effect on the current request.
- Reset mid-transaction: avm_write_o drops asynchronously and the shadow is invalidated, so the next request rewrites all digits.

Decomposition:
- Package hex_display_pkg:
  - state enum (IDLE, SCAN, WRITE, DONE)
  - constant DIGIT_W=4
  - constant SEG_BYTEENABLE=4'b0001
  - function for digit extraction by index
- Single module; no sub-module needed. A separate Avalon master-port sub-module adds nothing for single-beat writes.

Test Plan:
- First request after reset: value_i=24'h123456, force_i=0, no waitrequest → six writes; address/data 0/4'h6, 1/4'h5, 2/4'h4, 3/4'h3, 4/4'h2, 5/4'h1; byteenable 4'b0001 on each; done_o in cycle 13.
- Repeat 24'h123456 → zero writes, done_o in cycle 7. Then 24'h12A456 → exactly one write, address 3, writedata 32'hA.
- Resend 24'h12A456 with force_i=1 → all six writes issued.
- avm_waitrequest_i held high 3 cycles on the address-2 write → avm_write_o held for 4 cycles with address/data stable; exactly one shadow update; done_o delayed by 3 cycles.
- valid_i held high while busy with a different value → ignored until ready_o=1, then accepted once.
- rst_n pulsed low mid-WRITE → avm_write_o=0 immediately, ready_o=1. Next request with the same value writes all six digits.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and helpers for the hex display sequencer.
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DIGIT_W        = 4;
  localparam logic [3:0]  SEG_BYTEENABLE = 4'b0001;

  // Upper bound on digits the extraction helper can address.
  localparam int unsigned MAX_SEGMENT = 16;
  localparam int unsigned MAX_VALUE_W = MAX_SEGMENT * DIGIT_W;

  // Return digit idx of a packed (zero-extended) digit vector.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [MAX_VALUE_W-1:0] value,
                                                  input int unsigned idx);
    logic [MAX_VALUE_W-1:0] shifted;
    shifted = value >> (idx * DIGIT_W);
    return shifted[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/hex_display_sequencer_if.sv
// Request handshake plus Avalon-MM write port of the hex display sequencer.
interface hex_display_sequencer_if
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_SEGMENT = 6,
  parameter int unsigned ADDR_W      = 3
) ();

  logic [NUM_SEGMENT*DIGIT_W-1:0] value_i;
  logic                           force_i;
  logic                           valid_i;
  logic                           ready_o;
  logic                           busy_o;
  logic                           done_o;
  logic [ADDR_W-1:0]              avm_address_o;
  logic [3:0]                     avm_byteenable_o;
  logic                           avm_write_o;
  logic [31:0]                    avm_writedata_o;
  logic                           avm_waitrequest_i;

  // Sequencer side.
  modport master (
    input  value_i, force_i, valid_i, avm_waitrequest_i,
    output ready_o, busy_o, done_o,
           avm_address_o, avm_byteenable_o, avm_write_o, avm_writedata_o
  );

  // Requester / display slave side.
  modport slave (
    output value_i, force_i, valid_i, avm_waitrequest_i,
    input  ready_o, busy_o, done_o,
           avm_address_o, avm_byteenable_o, avm_write_o, avm_writedata_o
  );

endinterface

// File: rtl/hex_display_sequencer.sv
// Writes changed hex digits to the memory-mapped 7-segment display slave,
// one single-beat Avalon-MM write per digit, skipping digits already shown.
module hex_display_sequencer
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_SEGMENT = 6,
  parameter int unsigned ADDR_W      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hex_display_sequencer_if.master  bus
);

  localparam int unsigned       VALUE_W  = NUM_SEGMENT * DIGIT_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SEGMENT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [VALUE_W-1:0]  req_value_q, req_value_d;
  logic                req_force_q, req_force_d;
  logic [VALUE_W-1:0]  shadow_q, shadow_d;
  logic                shadow_valid_q, shadow_valid_d;

  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         data_q, data_d;

  logic [DIGIT_W-1:0]  cur_digit_c;
  logic [DIGIT_W-1:0]  shadow_digit_c;
  logic                need_write_c;
  logic                accept_c;
  int unsigned         digit_sh_c;

  // Current digit of the captured request versus the digit last written.
  assign digit_sh_c     = 32'(idx_q) * DIGIT_W;
  assign cur_digit_c    = digit_at(MAX_VALUE_W'(req_value_q), 32'(idx_q));
  assign shadow_digit_c = digit_at(MAX_VALUE_W'(shadow_q), 32'(idx_q));
  assign need_write_c   = req_force_q | ~shadow_valid_q | (cur_digit_c != shadow_digit_c);
  assign accept_c       = write_q & ~bus.avm_waitrequest_i;

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    req_value_d    = req_value_q;
    req_force_d    = req_force_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    addr_d         = addr_q;
    data_d         = data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.valid_i && ready_q) begin
          req_value_d = bus.value_i;
          req_force_d = bus.force_i;
          idx_d       = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (need_write_c) begin
          addr_d  = idx_q;
          data_d  = 32'(cur_digit_c);
          state_d = WRITE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      WRITE: begin
        if (accept_c) begin
          shadow_d = (shadow_q & ~(VALUE_W'({DIGIT_W{1'b1}}) << digit_sh_c))
                   | (VALUE_W'(cur_digit_c) << digit_sh_c);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        shadow_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status and strobe outputs follow the state being entered.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    write_d = (state_d == WRITE);
    be_d    = write_d ? SEG_BYTEENABLE : 4'b0000;
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      req_value_q    <= '0;
      req_force_q    <= 1'b0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      write_q        <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      req_value_q    <= req_value_d;
      req_force_q    <= req_force_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      write_q        <= write_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      data_q         <= data_d;
    end
  end

  assign bus.ready_o          = ready_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.avm_write_o      = write_q;
  assign bus.avm_address_o    = addr_q;
  assign bus.avm_byteenable_o = be_q;
  assign bus.avm_writedata_o  = data_q;

endmodule
